// File: rtl/my_decrementer_timer_16.sv
// Loadable 16-bit countdown timer with one-cycle expiry pulse and optional auto-reload.
// Expiry is detected at count==1 so the decrement never wraps.
module my_decrementer_timer_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        stop,
  input  logic        auto_reload,
  input  logic        tick,
  output logic [15:0] count,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [15:0] reload;
  logic [15:0] count_dec;

  // count - 1 through the shared 16-bit adder: add all-ones, drop the carry.
  assign count_dec = count + 16'hFFFF;

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (stop) begin
            state <= IDLE;
          end else if (load) begin
            count  <= load_value;
            reload <= load_value;
          end else if (start) begin
            if (count != '0) state <= RUN;
            else             done  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (load) begin
            count  <= load_value;
            reload <= load_value;
            if (load_value == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else if (tick) begin
            if (count == 16'd1) begin
              done <= 1'b1;
              if (auto_reload && (reload != '0)) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= IDLE;
              end
            end else if (count == '0) begin
              state <= IDLE;
            end else begin
              count <= count_dec;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_decrementer_timer_16.sv
// Scoreboard bench for my_decrementer_timer_16: stimulus queues hand-computed
// post-edge expectations, a monitor pops and compares them after each edge.
module tb_my_decrementer_timer_16;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        stop;
  logic        auto_reload;
  logic        tick;
  logic [15:0] count;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] c;
    logic        b;
    logic        d;
  } exp_t;

  exp_t  sb[$];
  int    compared;
  int    mismatched;
  string phase;

  my_decrementer_timer_16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .tick       (tick),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input logic ld, input logic [15:0] lv, input logic st, input logic sp,
                     input logic ar, input logic tk,
                     input logic [15:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    load = ld; load_value = lv; start = st; stop = sp; auto_reload = ar; tick = tk;
    e.c = ec; e.b = eb; e.d = ed;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_now(input string name, input logic [15:0] ec, input logic eb, input logic ed);
    compared++;
    if (count !== ec || busy !== eb || done !== ed) begin
      mismatched++;
      $display("FAIL %s: got count=%h busy=%b done=%b, expected count=%h busy=%b done=%b",
               name, count, busy, done, ec, eb, ed);
    end
  endtask

  // Assert reset between edges and check that outputs clear without waiting for a clock.
  task automatic async_reset(input string name);
    #3;
    rst_n = 1'b0;
    #1;
    check_now(name, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    load = 0; start = 0; stop = 0; auto_reload = 0; tick = 0;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        compared++;
        if (count !== e.c || busy !== e.b || done !== e.d) begin
          mismatched++;
          $display("FAIL %s @%0t: got count=%h busy=%b done=%b, expected count=%h busy=%b done=%b",
                   phase, $time, count, busy, done, e.c, e.b, e.d);
        end
      end
    end
  end

  initial begin : stimulus
    compared = 0; mismatched = 0;
    rst_n = 1'b0; load = 0; load_value = '0; start = 0; stop = 0; auto_reload = 0; tick = 0;
    phase = "reset";
    #2;
    check_now("reset_values", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    phase = "reset_mid_count";
    cyc(1, 16'd5, 0, 0, 0, 0, 16'd5, 0, 0);
    cyc(0, 16'd0, 1, 0, 0, 0, 16'd5, 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd4, 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd3, 1, 0);
    async_reset("async_reset_mid_run");

    phase = "basic";
    cyc(1, 16'd3, 0, 0, 0, 0, 16'd3, 0, 0);
    cyc(0, 16'd0, 1, 0, 0, 1, 16'd3, 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd2, 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd1, 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd0, 0, 1);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd0, 0, 0);

    phase = "auto_reload";
    cyc(1, 16'd2, 0, 0, 1, 0, 16'd2, 0, 0);
    cyc(0, 16'd0, 1, 0, 1, 1, 16'd2, 1, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(0, 16'd0, 0, 0, 1, 1, 16'd1, 1, 0);
      cyc(0, 16'd0, 0, 0, 1, 1, 16'd2, 1, 1);
    end
    cyc(0, 16'd0, 0, 1, 1, 1, 16'd2, 0, 0);

    phase = "sparse_stop";
    cyc(1, 16'hFFFF, 0, 0, 0, 0, 16'hFFFF, 0, 0);
    cyc(0, 16'd0, 1, 0, 0, 0, 16'hFFFF, 1, 0);
    for (int unsigned i = 1; i <= 4; i++) begin
      cyc(0, 16'd0, 0, 0, 0, 0, 16'(17'h10000 - i), 1, 0);
      cyc(0, 16'd0, 0, 0, 0, 0, 16'(17'h10000 - i), 1, 0);
      cyc(0, 16'd0, 0, 0, 0, 1, 16'(17'h0FFFF - i), 1, 0);
    end
    cyc(0, 16'd0, 0, 1, 0, 0, 16'hFFFB, 0, 0);
    cyc(0, 16'd0, 0, 0, 0, 0, 16'hFFFB, 0, 0);
    phase = "long_run";
    cyc(0, 16'd0, 1, 0, 0, 0, 16'hFFFB, 1, 0);
    for (int unsigned i = 1; i < 32'hFFFB; i++)
      cyc(0, 16'd0, 0, 0, 0, 1, 16'(32'hFFFB - i), 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd0, 0, 1);

    phase = "zero_load";
    cyc(1, 16'd0, 0, 0, 0, 0, 16'd0, 0, 0);
    cyc(0, 16'd0, 1, 0, 0, 1, 16'd0, 0, 1);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd0, 0, 0);

    phase = "load_one";
    cyc(1, 16'd1, 0, 0, 0, 0, 16'd1, 0, 0);
    cyc(0, 16'd0, 1, 0, 0, 0, 16'd1, 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd0, 0, 1);
    cyc(0, 16'd0, 0, 0, 0, 0, 16'd0, 0, 0);

    phase = "prio_stop";
    cyc(1, 16'd1, 0, 0, 0, 0, 16'd1, 0, 0);
    cyc(0, 16'd0, 1, 0, 0, 0, 16'd1, 1, 0);
    cyc(0, 16'd0, 0, 1, 0, 1, 16'd1, 0, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd1, 0, 0);

    phase = "prio_load";
    cyc(0, 16'd0, 1, 0, 0, 0, 16'd1, 1, 0);
    cyc(1, 16'd7, 0, 0, 0, 1, 16'd7, 1, 0);
    cyc(0, 16'd0, 1, 0, 0, 1, 16'd6, 1, 0);
    cyc(0, 16'd0, 0, 1, 0, 0, 16'd6, 0, 0);

    phase = "run_load_zero";
    cyc(0, 16'd0, 1, 0, 0, 0, 16'd6, 1, 0);
    cyc(1, 16'd0, 0, 0, 0, 1, 16'd0, 0, 1);
    cyc(0, 16'd0, 0, 0, 0, 0, 16'd0, 0, 0);

    phase = "reset_clears_done";
    cyc(1, 16'd1, 0, 0, 0, 0, 16'd1, 0, 0);
    cyc(0, 16'd0, 1, 0, 0, 0, 16'd1, 1, 0);
    cyc(0, 16'd0, 0, 0, 0, 1, 16'd0, 0, 1);
    async_reset("async_reset_pending_done");

    repeat (4) @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/my_decrementer_timer_16.md
# my_decrementer_timer_16

Loadable 16-bit countdown timer: the counting-down counterpart to the 16-bit incrementer. It holds a value, decrements it once per qualified `tick`, and signals expiry with a one-cycle `done` pulse. Optional auto-reload gives periodic operation. It sits beside the program counter as the machine's timer/delay peripheral and uses the same 16-bit gate library.

## Interface
- Parameters: none; width fixed at 16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load` input 1: write `load_value` into the count and reload registers.
- `load_value` input 16: value written by `load`.
- `start` input 1: begin counting (honoured in IDLE only).
- `stop` input 1: abort counting, return to IDLE, hold count.
- `auto_reload` input 1: on expiry, restart from reload register instead of stopping.
- `tick` input 1: count enable; one decrement per cycle where sampled high in RUN.
- `count` output 16: current count register.
- `busy` output 1: high in RUN.
- `done` output 1: registered one-cycle expiry pulse.

## Operation
- State: `count[15:0]`, `reload[15:0]`, `state` ∈ {IDLE, RUN}, `done` flop.
- Reset (`rst_n`=0, asynchronous): `count`=0, `reload`=0, state=IDLE, `busy`=0, `done`=0. Release is synchronous to the next edge.
- Decrement: `count - 1`, formed as `count + 16'hFFFF` mod 2^16 through the 16-bit adder. The timer never wraps, because expiry is detected at `count`==1.
- Priority each cycle: `stop` > `load` > `start`/`tick`.
- IDLE:
  - `load`=1: `count`<=`load_value` and `reload`<=`load_value`.
  - `start`=1 with `count`!=0: go to RUN.
  - `start`=1 with `count`==0: stay in IDLE and pulse `done` next cycle (zero-length timeout).
  - `tick` is ignored in IDLE.
- RUN:
  - `stop`=1: go to IDLE, `count` unchanged, no `done`.
  - `load`=1: update `count` and `reload`, stay in RUN, no decrement that cycle.
    - If `load_value`==0, go to IDLE and pulse `done`.
  - `tick`=1 with `count`>1: `count`<=`count`-1.
  - `tick`=1 with `count`==1: `done`<=1 and `count`<=0. Then:
    - If `auto_reload`=1 and `reload`!=0: `count`<=`reload` and stay in RUN.
    - Otherwise go to IDLE.
  - `start` is ignored in RUN.
- `done` is 0 in every cycle other than the one after an expiry event.
- `busy` = (state==RUN), decoded from the state register.

## Timing
- All outputs are registered or decoded from registers. There is no combinational input-to-output path.
- Load-to-count latency: 1 cycle.
- Start with `count`=N and `tick` held high:
  - Start edge E0: RUN begins (`busy`=1 after E0).
  - Decrements occur at E1..EN.
  - `done`=1 for the cycle after EN.
  - Without auto-reload, `busy`=0 after EN.
- Total duration: N+1 edges from `start` to `done`.
- Auto-reload with R and `tick` always high: `done` pulses every R cycles, and the count sequence runs R..1 with no 0 visible. The count shows `reload` in the `done` cycle.
- Sparse `tick`: expiry occurs on the Nth sampled-high `tick` after entering RUN.
- `stop` and expiry in the same cycle: `stop` wins, no `done`, `count` stays 1.
- Reset asserted mid-RUN: immediate return to reset values. A pending `done` is cleared.

## Test plan
- Reset mid-count: load 5, start, 2 ticks, assert `rst_n`=0 asynchronously between edges → `count`=0, `busy`=0 and `done`=0 immediately.
- Basic: load 3, start, `tick`=1 continuously → `count` 3,2,1,0; `done`=1 exactly in the cycle after the third tick edge; `busy` falls with it.
- Auto-reload: load 2, `auto_reload`=1, start, `tick`=1 for 8 cycles → `done` pulses every 2 cycles (4 pulses); `count` alternates 2,1; `busy` stays 1.
- Sparse ticks / stop: load 16'hFFFF, start, tick every 3rd cycle, `stop` after 4 ticks → `count`=16'hFFFB, IDLE, no `done`. Start again, 16'hFFFB more ticks → `done`.
- Zero and edge loads:
  - Load 0, start → `done` next cycle, never `busy`.
  - Load 1, start, one tick → `done`, `count`=0.
- Priority: in RUN at `count`=1 with `tick`=1:
  - `stop`=1 → no `done`, `count`=1.
  - `load`=1 with 7 → `count`=7, still RUN.
